hilo_unit: RTL and testbench

Multi-cycle HI/LO multiply/divide unit for the CPU-54 datapath. It executes MULT, MULTU, DIV and DIVU, and handles MTHI/MTLO writes into the architectural HI and LO registers. It drives the 32-bit `hilo` value consumed by the writeback select path for MFHI/MFLO. Control stalls the pipeline on `busy` and retires the operation on `done`.

---
 rtl/hilo_unit.sv | 149 ++++++++++++++
 tb/tb_hilo_unit.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/hilo_unit.sv
// hilo_unit: multi-cycle HI/LO multiply/divide unit.
// Runs MULT/MULTU (shift-add) and DIV/DIVU (restoring) over 32 iterations,
// and handles MTHI/MTLO writes. Results reach hi/lo only at commit.
// Optional build macro: HILO_FAST_MULT_EN selects a single-cycle multiplier
// for MULT/MULTU (IDLE -> FIN directly, busy never raised).
module hilo_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             rd_sel,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic [WIDTH-1:0] hilo
);

   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

   state_t           state_reg, state_next;
   logic [4:0]       cnt_reg;
   logic [WIDTH-1:0] acc_hi_reg, acc_lo_reg, opnd_reg;
   logic [WIDTH-1:0] hi_reg, lo_reg;
   logic             is_div_reg, neg_q_reg, neg_r_reg, dz_reg, fast_reg;
   logic             done_reg, div_zero_reg;

   // operand conditioning and per-iteration datapath
   logic             op_signed, md_start, fast_sel;
   logic [WIDTH-1:0] a_abs, b_abs;
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   div_shift;
   logic [WIDTH-1:0] div_diff;
   logic             div_ok;
   logic [2*WIDTH-1:0] prod_s;
   logic [WIDTH-1:0] q_s, r_s;

   // Combinational helpers: absolute operands, one mul/div step, sign fix-up
   always_comb begin
      op_signed = (op == 3'b000) || (op == 3'b010);
      a_abs     = (op_signed && a[WIDTH-1]) ? (~a + 1'b1) : a;
      b_abs     = (op_signed && b[WIDTH-1]) ? (~b + 1'b1) : b;
      md_start  = (state_reg == IDLE) && start && !op[2];
`ifdef HILO_FAST_MULT_EN
      fast_sel  = !op[1];
`else
      fast_sel  = 1'b0;
`endif
      // shift-add: add multiplicand into the upper half when the LSB is set
      mul_sum   = {1'b0, acc_hi_reg} + (acc_lo_reg[0] ? {1'b0, opnd_reg} : '0);
      // restoring divide: bring in next dividend bit, try to subtract
      div_shift = {acc_hi_reg, acc_lo_reg[WIDTH-1]};
      div_ok    = div_shift >= {1'b0, opnd_reg};
      div_diff  = div_shift[WIDTH-1:0] - opnd_reg;
      prod_s    = neg_q_reg ? (~{acc_hi_reg, acc_lo_reg} + 1'b1) : {acc_hi_reg, acc_lo_reg};
      q_s       = neg_q_reg ? (~acc_lo_reg + 1'b1) : acc_lo_reg;
      r_s       = neg_r_reg ? (~acc_hi_reg + 1'b1) : acc_hi_reg;
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_reg <= IDLE;
      else        state_reg <= state_next;
   end

   // FSM next-state logic
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: if (md_start) state_next = fast_sel ? FIN : RUN;
         RUN:  if (cnt_reg == 5'd0) state_next = FIN;
         FIN:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Working registers: operand capture and one iteration per RUN cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_reg    <= '0;
         acc_hi_reg <= '0;
         acc_lo_reg <= '0;
         opnd_reg   <= '0;
         is_div_reg <= 1'b0;
         neg_q_reg  <= 1'b0;
         neg_r_reg  <= 1'b0;
         dz_reg     <= 1'b0;
         fast_reg   <= 1'b0;
      end else if (md_start) begin
         cnt_reg    <= 5'd31;
         acc_hi_reg <= '0;
         acc_lo_reg <= a_abs;
         opnd_reg   <= b_abs;
         is_div_reg <= op[1];
         neg_q_reg  <= op_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
         neg_r_reg  <= op_signed && a[WIDTH-1];
         dz_reg     <= op[1] && (b == '0);
         fast_reg   <= fast_sel;
`ifdef HILO_FAST_MULT_EN
         if (fast_sel) {acc_hi_reg, acc_lo_reg} <= {{WIDTH{1'b0}}, a_abs} * {{WIDTH{1'b0}}, b_abs};
`endif
      end else if (state_reg == RUN) begin
         cnt_reg <= cnt_reg - 5'd1;
         if (is_div_reg) begin
            acc_hi_reg <= div_ok ? div_diff : div_shift[WIDTH-1:0];
            acc_lo_reg <= {acc_lo_reg[WIDTH-2:0], div_ok};
         end else begin
            acc_hi_reg <= mul_sum[WIDTH:1];
            acc_lo_reg <= {mul_sum[0], acc_lo_reg[WIDTH-1:1]};
         end
      end
   end

   // Architectural HI/LO: MT writes in IDLE, result commit in FIN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hi_reg       <= '0;
         lo_reg       <= '0;
         done_reg     <= 1'b0;
         div_zero_reg <= 1'b0;
      end else begin
         done_reg     <= (state_reg == FIN);
         div_zero_reg <= (state_reg == FIN) && is_div_reg && dz_reg;
         if (state_reg == IDLE && start && op == 3'b100) hi_reg <= a;
         if (state_reg == IDLE && start && op == 3'b101) lo_reg <= a;
         if (state_reg == FIN) begin
            if (!is_div_reg) begin
               {hi_reg, lo_reg} <= prod_s;
            end else if (!dz_reg) begin
               hi_reg <= r_s;
               lo_reg <= q_s;
            end
         end
      end
   end

   assign busy     = (state_reg == RUN) || (state_reg == FIN && !fast_reg);
   assign done     = done_reg;
   assign div_zero = div_zero_reg;
   assign hi       = hi_reg;
   assign lo       = lo_reg;
   assign hilo     = rd_sel ? hi_reg : lo_reg;

endmodule

// File: tb/tb_hilo_unit.sv
// tb_hilo_unit: directed-vector bench for hilo_unit.
// Builds with or without HILO_FAST_MULT_EN; multiply latency follows the macro.
module tb_hilo_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [2:0]  op = 3'b000;
   logic [31:0] a = '0, b = '0;
   logic        rd_sel = 1'b0;
   logic        busy, done, div_zero;
   logic [31:0] hi, lo, hilo;

   int tests = 0;
   int fails = 0;
   int done_cnt = 0;
   int lat;
   int d0;

`ifdef HILO_FAST_MULT_EN
   localparam int MLAT = 1;
   localparam logic MBUSY = 1'b0;
`else
   localparam int MLAT = 33;
   localparam logic MBUSY = 1'b1;
`endif

   localparam logic [2:0] OP_MULT = 3'b000, OP_MULTU = 3'b001, OP_DIV = 3'b010,
                          OP_DIVU = 3'b011, OP_MTHI = 3'b100, OP_MTLO = 3'b101;

   hilo_unit #(.WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
      .rd_sel(rd_sel), .busy(busy), .done(done), .div_zero(div_zero),
      .hi(hi), .lo(lo), .hilo(hilo)
   );

   always #5 clk = ~clk;

   // count every done pulse seen at a rising edge
   always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("[TB] FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end else begin
         $display("[TB] ok   %s = 0x%0h", tag, got);
      end
   endtask

   // drive one start; returns #1 after the accepting edge E0
   task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
      @(negedge clk);
      start = 1'b1; op = o; a = x; b = y;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // cycles from E0 until done is seen, bounded
   task automatic wait_done(output int n);
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!done && n < 100);
   endtask

   task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                         input logic [31:0] y, input int exp_lat, input logic [31:0] ehi,
                         input logic [31:0] elo, input logic edz);
      int n;
      issue(o, x, y);
      wait_done(n);
      check({tag, "_lat"}, 64'(n), 64'(exp_lat));
      check({tag, "_dz"},  64'(div_zero), 64'(edz));
      check({tag, "_hi"},  64'(hi), 64'(ehi));
      check({tag, "_lo"},  64'(lo), 64'(elo));
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check("rst_hi", 64'(hi), 64'h0);
      check("rst_lo", 64'(lo), 64'h0);
      check("rst_busy", 64'(busy), 64'h0);
      check("rst_done", 64'(done), 64'h0);
      @(negedge clk); rst_n = 1'b1;

      // MTHI / MTLO and read select
      issue(OP_MTHI, 32'hDEADBEEF, 32'h0);
      check("mthi_hi", 64'(hi), 64'hDEADBEEF);
      check("mthi_busy", 64'(busy), 64'h0);
      issue(OP_MTLO, 32'h12345678, 32'h0);
      check("mtlo_lo", 64'(lo), 64'h12345678);
      rd_sel = 1'b1; #1;
      check("hilo_hi", 64'(hilo), 64'hDEADBEEF);
      rd_sel = 1'b0; #1;
      check("hilo_lo", 64'(hilo), 64'h12345678);

      // partial results stay hidden while a multiply is in flight
      issue(OP_MULT, 32'hFFFFFFFF, 32'd2);
      check("mult_busy", 64'(busy), 64'(MBUSY));
      check("mult_hold_hi", 64'(hi), 64'hDEADBEEF);
      wait_done(lat);
      check("mult_lat", 64'(lat), 64'(MLAT));
      check("mult_hi", 64'(hi), 64'hFFFFFFFF);
      check("mult_lo", 64'(lo), 64'hFFFFFFFE);

      run_op("multu", OP_MULTU, 32'hFFFFFFFF, 32'd2, MLAT, 32'h00000001, 32'hFFFFFFFE, 1'b0);
      run_op("div_m7", OP_DIV,  32'hFFFFFFF9, 32'd2, 33, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
      run_op("divu_7", OP_DIVU, 32'hFFFFFFF9, 32'd2, 33, 32'h00000001, 32'h7FFFFFFC, 1'b0);
      run_op("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 33, 32'h0, 32'h80000000, 1'b0);
      run_op("mult_neg", OP_MULT, 32'hFFFFFFFD, 32'd7, MLAT, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);

      // divide by zero leaves preloaded HI/LO
      issue(OP_MTHI, 32'h11, 32'h0);
      issue(OP_MTLO, 32'h22, 32'h0);
      run_op("divz", OP_DIVU, 32'd100, 32'd0, 33, 32'h11, 32'h22, 1'b1);
      @(posedge clk); #1;
      check("divz_pulse_end", 64'(div_zero), 64'h0);

`ifndef HILO_FAST_MULT_EN
      // a second start while busy is ignored
      d0 = done_cnt;
      issue(OP_MULT, 32'd3, 32'd5);
      repeat (3) @(posedge clk);
      issue(OP_MULT, 32'd7, 32'd7);
      wait_done(lat);
      check("ign_lat", 64'(lat), 64'd29);
      check("ign_lo", 64'(lo), 64'd15);
      check("ign_hi", 64'(hi), 64'd0);
      repeat (40) @(posedge clk); #1;
      check("ign_done_cnt", 64'(done_cnt - d0), 64'd1);
`endif

      // back-to-back: DIVU issued in the MULTU done cycle
      issue(OP_MULTU, 32'd6, 32'd7);
      wait_done(lat);
      check("b2b_mul_lat", 64'(lat), 64'(MLAT));
      check("b2b_mul_lo", 64'(lo), 64'd42);
      check("b2b_done_busy", 64'(busy), 64'h0);
      start = 1'b1; op = OP_DIVU; a = 32'd100; b = 32'd7;
      @(posedge clk); #1;
      start = 1'b0;
      check("b2b_div_busy", 64'(busy), 64'h1);
      wait_done(lat);
      check("b2b_div_lat", 64'(lat), 64'd33);
      check("b2b_div_lo", 64'(lo), 64'd14);
      check("b2b_div_hi", 64'(hi), 64'd2);

      // asynchronous reset in the middle of a divide
      issue(OP_DIV, 32'd1000, 32'd3);
      repeat (10) @(posedge clk);
      @(negedge clk); #2;
      rst_n = 1'b0; #1;
      check("mid_rst_hi", 64'(hi), 64'h0);
      check("mid_rst_lo", 64'(lo), 64'h0);
      check("mid_rst_busy", 64'(busy), 64'h0);
      d0 = done_cnt;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(posedge clk); #1;
      check("mid_rst_no_done", 64'(done_cnt - d0), 64'd0);
      check("mid_rst_lo_after", 64'(lo), 64'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
